// File: rtl/codec_cfg_pkg.sv
// Shared state encoding, command word layout and the codec boot table.
package codec_cfg_pkg;

   localparam int         NUM_BOOT_REGS = 11;
   localparam logic [7:0] DEV_ADDR      = 8'h34;

   typedef enum logic [2:0] {
      BOOT_ISSUE,
      BOOT_WAIT,
      DELAY,
      DONE,
      HOST_WAIT,
      ERROR
   } state_t;

   typedef struct packed {
      logic [6:0] regno;
      logic [8:0] data;
   } cfg_word_t;

   // Entry 0 resets the codec; everything after it waits for the post-reset delay.
   function automatic cfg_word_t boot_word(input logic [7:0] idx);
      cfg_word_t w;
      case (idx)
         8'd0:    w = '{7'd15, 9'h000};
         8'd1:    w = '{7'd6,  9'h000};
         8'd2:    w = '{7'd0,  9'h017};
         8'd3:    w = '{7'd1,  9'h017};
         8'd4:    w = '{7'd2,  9'h079};
         8'd5:    w = '{7'd3,  9'h079};
         8'd6:    w = '{7'd4,  9'h012};
         8'd7:    w = '{7'd5,  9'h000};
         8'd8:    w = '{7'd7,  9'h042};
         8'd9:    w = '{7'd8,  9'h000};
         8'd10:   w = '{7'd9,  9'h001};
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/codec_config_sequencer.sv
// Boots the codec over I2C from a fixed table, then arbitrates host register writes onto the same master.
// One transfer in flight; boot holds host_req off, host_ack pulses one cycle after i2c_done.
module codec_config_sequencer #(
   parameter int         NUM_REGS        = codec_cfg_pkg::NUM_BOOT_REGS,
   parameter int         MAX_RETRY       = 3,
   parameter int         POST_RESET_WAIT = 50000,
   parameter logic [7:0] DEV_ADDR        = codec_cfg_pkg::DEV_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reconfig,
   input  logic        host_req,
   input  logic [6:0]  host_reg,
   input  logic [8:0]  host_data,
   output logic        host_ack,
   output logic        host_err,
   output logic        i2c_req,
   output logic [7:0]  i2c_dev,
   output logic [15:0] i2c_word,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   output logic        busy,
   output logic        config_done,
   output logic        error
);
   import codec_cfg_pkg::*;

   localparam int IW = $clog2(NUM_REGS);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int CW = $clog2(POST_RESET_WAIT + 1);

   localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_REGS - 1);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
   localparam logic [CW-1:0] DELAY_LAST  = CW'(POST_RESET_WAIT - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [CW-1:0] cnt_q, cnt_d;
   cfg_word_t     word_q, word_d;
   logic          pend_q, pend_d;
   logic          req_d, ack_d, err_d, cfg_done_d, error_d;
   logic          restart;

   assign i2c_dev  = DEV_ADDR;
   assign i2c_word = word_q;
   assign busy     = (state_q != DONE) && (state_q != ERROR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= BOOT_ISSUE;
         idx_q       <= '0;
         retry_q     <= '0;
         cnt_q       <= '0;
         word_q      <= '0;
         pend_q      <= 1'b0;
         i2c_req     <= 1'b0;
         host_ack    <= 1'b0;
         host_err    <= 1'b0;
         config_done <= 1'b0;
         error       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         retry_q     <= retry_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         pend_q      <= pend_d;
         i2c_req     <= req_d;
         host_ack    <= ack_d;
         host_err    <= err_d;
         config_done <= cfg_done_d;
         error       <= error_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      retry_d    = retry_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      pend_d     = pend_q;
      req_d      = i2c_req;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      cfg_done_d = config_done;
      error_d    = error;
      restart    = 1'b0;

      case (state_q)
         BOOT_ISSUE: begin
            word_d  = boot_word(8'(idx_q));
            req_d   = 1'b1;
            state_d = BOOT_WAIT;
         end
         BOOT_WAIT: begin
            if (i2c_req && i2c_done) begin
               req_d = 1'b0;
               if (i2c_nack) begin
                  if (retry_q < RETRY_LIMIT) begin
                     retry_d = retry_q + 1'b1;
                     state_d = BOOT_ISSUE;
                  end else begin
                     error_d = 1'b1;
                     state_d = ERROR;
                  end
               end else if (idx_q == '0) begin
                  cnt_d   = '0;
                  state_d = DELAY;
               end else if (idx_q == LAST_IDX) begin
                  cfg_done_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  retry_d = '0;
                  state_d = BOOT_ISSUE;
               end
            end
         end
         DELAY: begin
            if (cnt_q == DELAY_LAST) begin
               idx_d   = IW'(1);
               retry_d = '0;
               state_d = BOOT_ISSUE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            // A reconfig deferred from the last host write outranks a waiting host_req.
            if (reconfig || pend_q) begin
               restart = 1'b1;
            end else if (host_req) begin
               word_d  = '{host_reg, host_data};
               req_d   = 1'b1;
               state_d = HOST_WAIT;
            end
         end
         HOST_WAIT: begin
            pend_d = pend_q | reconfig;
            if (i2c_req && i2c_done) begin
               req_d   = 1'b0;
               ack_d   = 1'b1;
               err_d   = i2c_nack;
               state_d = DONE;
            end
         end
         ERROR: begin
            if (reconfig) restart = 1'b1;
         end
         default: state_d = BOOT_ISSUE;
      endcase

      if (restart) begin
         cfg_done_d = 1'b0;
         error_d    = 1'b0;
         idx_d      = '0;
         retry_d    = '0;
         pend_d     = 1'b0;
         state_d    = BOOT_ISSUE;
      end
   end

endmodule
